// File: rtl/bram_arb2.sv
// Two-requester arbiter sharing one BRAM port between a host loader (m0)
// and a CNN engine (m1); round-robin with a bounded burst lock.
module bram_arb2 #(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_din,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_din,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [31:0] m0_dout,
  output logic [31:0] m1_dout,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] bram_addr,
  output logic [3:0]  bram_we,
  output logic        bram_en,
  output logic [31:0] bram_din,
  input  logic [31:0] bram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last_served;
  logic        lock_q;
  logic [7:0]  lock_cnt;
  logic        tag_v;
  logic        tag_id;
  logic [31:0] hold_addr;
  logic [31:0] hold_din;
  logic        g0;
  logic        g1;
  logic        keep0;
  logic        keep1;
  logic        rpt;

  assign keep0 = (state == OWN0) && m0_req && lock_q
               && (lock_cnt < LOCK_LIM);
  assign keep1 = (state == OWN1) && m1_req && lock_q
               && (lock_cnt < LOCK_LIM);
  assign rpt   = ((state == OWN0) && g0) || ((state == OWN1) && g1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Lock keeps ownership first; otherwise round-robin on last_served.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (keep0) begin
        g0 = 1'b1;
      end else if (keep1) begin
        g1 = 1'b1;
      end else if (m0_req && m1_req) begin
        g0 = last_served;
        g1 = !last_served;
      end else if (m0_req) begin
        g0 = 1'b1;
      end else if (m1_req) begin
        g1 = 1'b1;
      end
    end
    state_nxt = IDLE;
    if (g0) begin
      state_nxt = OWN0;
    end else if (g1) begin
      state_nxt = OWN1;
    end
  end

  always_comb begin
    m0_gnt    = g0;
    m1_gnt    = g1;
    bram_en   = g0 | g1;
    bram_we   = 4'h0;
    bram_addr = hold_addr;
    bram_din  = hold_din;
    if (rst) begin
      bram_addr = 32'h0;
      bram_din  = 32'h0;
    end else if (g1) begin
      bram_we   = m1_we;
      bram_addr = m1_addr;
      bram_din  = m1_din;
    end else if (g0) begin
      bram_we   = m0_we;
      bram_addr = m0_addr;
      bram_din  = m0_din;
    end
    // Gating on rst drops a return already tagged when reset hits.
    m0_rvalid = tag_v && !tag_id && !rst;
    m1_rvalid = tag_v && tag_id && !rst;
    m0_dout   = bram_dout;
    m1_dout   = bram_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_served <= 1'b1;
      lock_q      <= 1'b0;
      lock_cnt    <= 8'h0;
      tag_v       <= 1'b0;
      tag_id      <= 1'b0;
      hold_addr   <= 32'h0;
      hold_din    <= 32'h0;
    end else begin
      tag_v  <= bram_en && (bram_we == 4'h0);
      tag_id <= g1;
      if (rpt) begin
        if (lock_cnt != 8'hFF) begin
          lock_cnt <= lock_cnt + 8'h1;
        end
      end else begin
        lock_cnt <= 8'h0;
      end
      if (bram_en) begin
        last_served <= g1;
        lock_q      <= g1 ? m1_lock : m0_lock;
        hold_addr   <= bram_addr;
        hold_din    <= bram_din;
      end
    end
  end

endmodule

// File: tb/tb_bram_arb2.sv
// Directed bench for bram_arb2: grants checked inline, read returns
// checked by a scoreboard monitor against a queue of expected words.
module tb_bram_arb2;

  logic        clk;
  logic        rst;
  logic        m0_req, m1_req, m0_lock, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_din, m1_din;
  logic [3:0]  m0_we, m1_we;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_dout, m1_dout;
  logic [31:0] bram_addr, bram_din, bram_dout;
  logic [3:0]  bram_we;
  logic        bram_en;

  int checks;
  int errors;
  bit done;

  bit          qid[$];
  logic [31:0] qdat[$];
  logic [31:0] mem [0:255];

  bram_arb2 #(.MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_we(m0_we), .m0_din(m0_din),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_we(m1_we), .m1_din(m1_din),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_en(bram_en),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple BRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b])
          mem[bram_addr[9:2]][8*b +: 8] <= bram_din[8*b +: 8];
      bram_dout <= mem[bram_addr[9:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_rd(input bit id, input logic [31:0] d);
    qid.push_back(id);
    qdat.push_back(d);
  endtask

  task automatic step(input string nm, input bit e0, input bit e1);
    @(negedge clk);
    chk({nm, "_gnt"}, {30'h0, m1_gnt, m0_gnt}, {30'h0, e1, e0});
    @(posedge clk);
    #1;
  endtask

  task automatic rst_outs(input string nm);
    @(negedge clk);
    chk({nm, "_gnt"}, {30'h0, m1_gnt, m0_gnt}, 32'h0);
    chk({nm, "_rv"}, {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    chk({nm, "_en_we"}, {27'h0, bram_en, bram_we}, 32'h0);
    chk({nm, "_addr"}, bram_addr, 32'h0);
    chk({nm, "_din"}, bram_din, 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for read returns
  always @(negedge clk) begin
    if (!done && (m0_rvalid || m1_rvalid)) begin
      checks++;
      if (m0_rvalid && m1_rvalid) begin
        errors++;
        $display("FAIL rv_both got 2 returns expected 1 at %0t", $time);
      end else if (qid.size() == 0) begin
        errors++;
        $display("FAIL rv_spurious got rvalid m%0d expected none at %0t",
                 m1_rvalid, $time);
      end else begin
        automatic bit          id = qid.pop_front();
        automatic logic [31:0] d  = qdat.pop_front();
        automatic logic [31:0] a  = m1_rvalid ? m1_dout : m0_dout;
        if (m1_rvalid !== id || a !== d) begin
          errors++;
          $display("FAIL rv_data got m%0d %h expected m%0d %h at %0t",
                   m1_rvalid, a, id, d, $time);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;
    mem[8'h0C] = 32'hA5A50001;
    bram_dout = 32'h0;
    checks = 0;
    errors = 0;
    done = 1'b0;
    rst = 1'b1;
    m0_req = 1'b1; m0_lock = 1'b0; m0_addr = 32'h10;
    m0_we = 4'h0;  m0_din = 32'h1111_0000;
    m1_req = 1'b1; m1_lock = 1'b0; m1_addr = 32'h30;
    m1_we = 4'h0;  m1_din = 32'h2222_0000;

    // Reset with both requesting
    rst_outs("rst0");
    rst_outs("rst1");
    rst = 1'b0;

    // m0 wins the first tie, then m1
    exp_rd(1'b0, 32'hDEADBEEF);
    step("first", 1'b1, 1'b0);
    exp_rd(1'b1, 32'hA5A50001);
    step("second", 1'b0, 1'b1);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk("idle_en_we", {27'h0, bram_en, bram_we}, 32'h0);
    chk("idle_hold_addr", bram_addr, 32'h30);
    @(posedge clk);
    #1;

    // Fairness: alternate 0,1,... with back-to-back reads
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) exp_rd(1'b0, 32'hDEADBEEF);
      else exp_rd(1'b1, 32'hA5A50001);
      step($sformatf("fair%0d", i), (i % 2 == 0), (i % 2 == 1));
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step("idle1", 1'b0, 1'b0);

    // Lock bound with MAX_LOCK=4
    m1_req = 1'b1; m1_lock = 1'b1;
    exp_rd(1'b1, 32'hA5A50001);
    step("lockA", 1'b0, 1'b1);
    m0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_rd(1'b1, 32'hA5A50001);
      step($sformatf("lock%0d", i), 1'b0, 1'b1);
    end
    exp_rd(1'b0, 32'hDEADBEEF);
    step("lock_yield", 1'b1, 1'b0);
    exp_rd(1'b1, 32'hA5A50001);
    step("lock_back", 1'b0, 1'b1);
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    step("idle2", 1'b0, 1'b0);

    // Write by m0, then read back by m1
    m0_req = 1'b1; m0_we = 4'hF; m0_addr = 32'h20;
    m0_din = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
    chk("wr_we", {28'h0, bram_we}, 32'hF);
    chk("wr_addr", bram_addr, 32'h20);
    chk("wr_din", bram_din, 32'h12345678);
    @(posedge clk);
    #1;
    m0_req = 1'b0; m0_we = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h20;
    exp_rd(1'b1, 32'h12345678);
    step("rd_back", 1'b0, 1'b1);
    m1_req = 1'b0;
    step("idle3", 1'b0, 1'b0);

    // Reset mid-read: tagged return must be dropped
    m1_req = 1'b1; m1_addr = 32'h10;
    step("rst_rd", 1'b0, 1'b1);
    m1_req = 1'b0;
    rst = 1'b1;
    rst_outs("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_rv", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;

    done = 1'b1;
    chk("sb_empty", qid.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
